hex_7seg_scan: RTL and testbench

- Multi-digit, time-multiplexed hex display driver.
- Generalises the single-digit hex-to-7-segment decoder to NUM_DIGITS digits sharing one segment bus.
- Adds a load-strobed shadow register, a refresh prescaler, an anti-ghosting blank gap, per-digit blanking, decimal points, leading-zero suppression and a frame tick.
- Sits between the datapath and the board's common-anode display.

---
 rtl/hex_7seg_scan.sv | 140 ++++++++++++++
 tb/tb_hex_7seg_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hex_7seg_scan.sv
// rtl/hex_7seg_scan.sv - time-multiplexed multi-digit hex driver for a common-anode 7-segment display

module hex_7seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int GAP        = 16,
  localparam int IW        = $clog2(NUM_DIGITS),
  localparam int CW        = $clog2(DIV)
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] HexVals,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   Blank,
  input  logic                    LzEn,
  output logic [0:6]              Leds,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic [IW-1:0]           DigitIdx,
  output logic                    FrameTick
);

  // Segment patterns are written a..g left to right, 0 = segment lit.
  function automatic logic [0:6] decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [0:6]              leds_q, leds_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    tick_q, tick_d;

  logic                    slot_end;
  logic [NUM_DIGITS-1:0]   sup;
  logic                    all_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_sup;
  logic                    in_gap;
  logic                    lit;

  // Prescaler, slot index and shadow register next state; the frame tick
  // fires on the edge that wraps the last slot back to digit 0.
  always_comb begin
    slot_end = (cnt_q == CW'(DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    val_d  = Load ? HexVals : val_q;
    dp_d   = Load ? DpIn : dp_q;
    tick_d = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
  end

  // Per-digit suppression: forced blank, or a leading zero when digits from
  // the top down to this one are all zero (digit 0 always shows).
  always_comb begin
    sup      = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (val_d[4*i +: 4] == 4'h0);
      sup[i]   = Blank[i] || (LzEn && (i != 0) && all_zero);
    end
  end

  // Outputs are computed from the next-state slot so they change on the
  // same edge as DigitIdx and the shadow register.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_sup = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_nib = val_d[4*i +: 4];
        cur_dp  = dp_d[i];
        cur_sup = sup[i];
      end
    end
    in_gap = (int'(cnt_d) < GAP);
    lit    = !in_gap && !cur_sup;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_d[i] = !(lit && (idx_d == IW'(i)));
    end
    leds_d = lit ? decode(cur_nib) : 7'b1111111;
    dpo_d  = lit ? !cur_dp : 1'b1;
  end

  // State and registered output update; reset forces everything dark at once.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      leds_q  <= 7'b1111111;
      dpo_q   <= 1'b1;
      anode_q <= '1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      leds_q  <= leds_d;
      dpo_q   <= dpo_d;
      anode_q <= anode_d;
      tick_q  <= tick_d;
    end
  end

  assign Leds      = leds_q;
  assign Dp        = dpo_q;
  assign Anode     = anode_q;
  assign DigitIdx  = idx_q;
  assign FrameTick = tick_q;

endmodule

// File: tb/tb_hex_7seg_scan.sv
// tb/tb_hex_7seg_scan.sv - directed bench for hex_7seg_scan (4 digits DIV=8 GAP=2, plus 3 digits DIV=3 GAP=0)

module tb_hex_7seg_scan;

  logic        Clock;
  logic        Reset_n;
  logic        Load;
  logic [15:0] HexVals;
  logic [3:0]  DpIn;
  logic [3:0]  Blank;
  logic        LzEn;
  logic [0:6]  Leds;
  logic        Dp;
  logic [3:0]  Anode;
  logic [1:0]  DigitIdx;
  logic        FrameTick;

  logic [11:0] hex_b;
  logic [2:0]  dpin_b;
  logic [2:0]  blank_b;
  logic        lzen_b;
  logic [0:6]  leds_b;
  logic        dp_b;
  logic [2:0]  anode_b;
  logic [1:0]  idx_b;
  logic        tick_b;

  int tests;
  int failed;
  int ecount;

  hex_7seg_scan #(.NUM_DIGITS(4), .DIV(8), .GAP(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Load(Load), .HexVals(HexVals),
    .DpIn(DpIn), .Blank(Blank), .LzEn(LzEn), .Leds(Leds), .Dp(Dp),
    .Anode(Anode), .DigitIdx(DigitIdx), .FrameTick(FrameTick)
  );

  hex_7seg_scan #(.NUM_DIGITS(3), .DIV(3), .GAP(0)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .Load(Load), .HexVals(hex_b),
    .DpIn(dpin_b), .Blank(blank_b), .LzEn(lzen_b), .Leds(leds_b), .Dp(dp_b),
    .Anode(anode_b), .DigitIdx(idx_b), .FrameTick(tick_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", tag, ecount, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t[0]  = 7'b0000001; t[1]  = 7'b1001111; t[2]  = 7'b0010010; t[3]  = 7'b0000110;
    t[4]  = 7'b1001100; t[5]  = 7'b0100100; t[6]  = 7'b0100000; t[7]  = 7'b0001111;
    t[8]  = 7'b0000000; t[9]  = 7'b0000100; t[10] = 7'b0001000; t[11] = 7'b1100000;
    t[12] = 7'b0110001; t[13] = 7'b1000010; t[14] = 7'b0110000; t[15] = 7'b0111000;
    return t[n];
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
    ecount++;
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] dp);
    HexVals = v;
    DpIn    = dp;
    Load    = 1'b1;
    tick();
    Load    = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] supm);
    int c, idx;
    logic lit;
    logic [3:0] ea;
    for (int k = 0; k < n; k++) begin
      tick();
      c   = ecount % 8;
      idx = (ecount / 8) % 4;
      lit = (c >= 2) && !supm[idx];
      ea  = 4'hF;
      if (lit) ea[idx] = 1'b0;
      check("anode", 32'(Anode), 32'(ea));
      check("leds", 32'(Leds), lit ? 32'(seg(v[4*idx +: 4])) : 32'h7F);
      check("dp", 32'(Dp), lit ? 32'(!dp[idx]) : 32'd1);
      check("idx", 32'(DigitIdx), 32'(idx));
      check("frametick", 32'(FrameTick), 32'((c == 0) && (idx == 0)));
    end
  endtask

  task automatic wait_slot(input int c, input int idx);
    for (int k = 0; k < 64; k++) begin
      if ((ecount % 8 == c) && ((ecount / 8) % 4 == idx)) return;
      tick();
    end
    check("wait_slot_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_anode", 32'(Anode), 32'hF);
    check("rst_leds", 32'(Leds), 32'h7F);
    check("rst_dp", 32'(Dp), 32'd1);
    check("rst_idx", 32'(DigitIdx), 32'd0);
    check("rst_tick", 32'(FrameTick), 32'd0);
    check("rst_anode_b", 32'(anode_b), 32'h7);
    check("rst_tick_b", 32'(tick_b), 32'd0);
  endtask

  initial begin
    int ib;
    logic [2:0] eab;
    tests   = 0;
    failed  = 0;
    ecount  = 0;
    Reset_n = 1'b0;
    Load    = 1'b0;
    HexVals = 16'h0;
    DpIn    = 4'h0;
    Blank   = 4'h0;
    LzEn    = 1'b0;
    hex_b   = 12'h5A7;
    dpin_b  = 3'b001;
    blank_b = 3'b000;
    lzen_b  = 1'b0;

    #22;
    check_reset_outputs();
    @(negedge Clock);
    Reset_n = 1'b1;
    ecount  = 0;

    // 12AF on four digits, across a frame wrap
    load_pulse(16'h12AF, 4'h0);
    run_frame(40, 16'h12AF, 4'h0, 4'h0);

    // Asynchronous reset in the middle of a lit window
    wait_slot(4, 1);
    check("pre_rst_anode", 32'(Anode), 32'hD);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge Clock);
    Reset_n = 1'b1;
    ecount  = 0;
    run_frame(12, 16'h0000, 4'h0, 4'h0);

    // Leading-zero suppression
    LzEn = 1'b1;
    load_pulse(16'h0050, 4'h0);
    run_frame(32, 16'h0050, 4'h0, 4'b1100);
    load_pulse(16'h0000, 4'h0);
    run_frame(32, 16'h0000, 4'h0, 4'b1110);

    // Load mid-slot updates segments on the same edge
    LzEn = 1'b0;
    wait_slot(4, 0);
    check("midload_pre_leds", 32'(Leds), 32'(7'b0000001));
    check("midload_pre_anode", 32'(Anode), 32'hE);
    load_pulse(16'h0003, 4'h0);
    check("midload_leds", 32'(Leds), 32'(7'b0000110));
    check("midload_anode", 32'(Anode), 32'hE);
    check("midload_idx", 32'(DigitIdx), 32'd0);

    // Blanking and decimal points
    Blank = 4'b0100;
    load_pulse(16'h1234, 4'b0101);
    run_frame(32, 16'h1234, 4'b0101, 4'b0100);

    // Three digits, no gap: continuous scan, tick every 9 cycles
    for (int k = 0; k < 20; k++) begin
      tick();
      ib  = (ecount / 3) % 3;
      eab = 3'b111;
      eab[ib] = 1'b0;
      check("b_idx", 32'(idx_b), 32'(ib));
      check("b_anode", 32'(anode_b), 32'(eab));
      check("b_leds", 32'(leds_b), 32'(seg(hex_b[4*ib +: 4])));
      check("b_dp", 32'(dp_b), 32'(!dpin_b[ib]));
      check("b_tick", 32'(tick_b), 32'(ecount % 9 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
